gpu_frame_sequencer: RTL and testbench

Avalon-MM master that drives the voxel GPU's `s1` register slave to render one complete frame without CPU involvement. On `start` it loads the 15 camera registers, then for every shader strip it issues start-pixel, rasterize-voxel, shade-entry and write-pixel commands. After each command it waits for `irq` and acknowledges it with a status read. It sits between the voxel/palette RAMs and the GPU, replacing the CPU-side command loop.

---
 rtl/gpu_frame_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_gpu_frame_sequencer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_frame_sequencer.sv
// Avalon-MM master that renders one voxel-GPU frame from camera, voxel
// and palette tables, acknowledging every command's irq with a status read.
module gpu_frame_sequencer #(
    parameter int H_RESOLUTION   = 320,
    parameter int V_RESOLUTION   = 240,
    parameter int NUM_SHADERS    = 320,
    parameter int VOX_ADDR_BITS  = 12,
    parameter int PAL_ADDR_BITS  = 8,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [VOX_ADDR_BITS:0]   num_voxels,
    input  logic [PAL_ADDR_BITS:0]   num_palette,
    input  logic [479:0]             cam_words,
    output logic [VOX_ADDR_BITS-1:0] vox_addr,
    input  logic [31:0]              vox_rdata,
    output logic [PAL_ADDR_BITS-1:0] pal_addr,
    input  logic [31:0]              pal_rdata,
    output logic [7:0]               gpu_address,
    output logic                     gpu_read,
    output logic                     gpu_write,
    output logic [31:0]              gpu_writedata,
    input  logic [31:0]              gpu_readdata,
    input  logic                     gpu_waitrequest,
    input  logic                     gpu_irq,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [1:0]               error_code
);

    localparam int TOTAL    = H_RESOLUTION * V_RESOLUTION;
    localparam int COL_BITS = $clog2(H_RESOLUTION);
    localparam int ROW_BITS = $clog2(V_RESOLUTION);
    localparam int PW       = $clog2(TOTAL + NUM_SHADERS + 1);
    localparam int SW       = $clog2(NUM_SHADERS + 1);
    localparam int TW       = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CAM_WR, S_STRIP_WR, S_VOX_FETCH, S_VOX_WR, S_PAL_FETCH,
        S_PAL_WR, S_PIX_WR, S_WAIT_IRQ, S_ACK_RD, S_RECOVER, S_DONE
    } state_t;

    typedef enum logic [1:0] {C_STRIP, C_VOX, C_PAL, C_PIX} cmd_t;

    state_t                 state_q, ack_next_d, after_vox_d;
    cmd_t                   last_q;
    logic [VOX_ADDR_BITS:0] num_vox_q, vox_idx_q, vox_inc_d;
    logic [PAL_ADDR_BITS:0] num_pal_q, pal_idx_q, pal_inc_d;
    logic [447:0]           cam_q;
    logic [3:0]             cam_idx_q;
    logic [PW-1:0]          start_pixel_q, pix_q, sp_next_d;
    logic [SW-1:0]          pix_cnt_q;
    logic [COL_BITS-1:0]    col_q;
    logic [ROW_BITS-1:0]    row_q;
    logic [TW-1:0]          timer_q;
    logic [7:0]             gpu_address_q;
    logic                   gpu_read_q, gpu_write_q;
    logic [31:0]            gpu_writedata_q, pix_word_d;
    logic                   busy_q, done_q, error_q, strip_end_d;
    logic [1:0]             error_code_q;

    assign vox_addr      = vox_idx_q[VOX_ADDR_BITS-1:0];
    assign pal_addr      = pal_idx_q[PAL_ADDR_BITS-1:0];
    assign gpu_address   = gpu_address_q;
    assign gpu_read      = gpu_read_q;
    assign gpu_write     = gpu_write_q;
    assign gpu_writedata = gpu_writedata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign error_code    = error_code_q;

    // Pixel counters already point at the next pixel when the ack completes.
    always_comb begin
        vox_inc_d   = vox_idx_q + (VOX_ADDR_BITS + 1)'(1);
        pal_inc_d   = pal_idx_q + (PAL_ADDR_BITS + 1)'(1);
        sp_next_d   = start_pixel_q + PW'(NUM_SHADERS);
        pix_word_d  = 32'({row_q, col_q, 1'b0});
        strip_end_d = (pix_cnt_q == SW'(NUM_SHADERS)) || (pix_q == PW'(TOTAL));
        after_vox_d = (num_pal_q != '0) ? S_PAL_FETCH : S_PIX_WR;
        ack_next_d  = S_PIX_WR;
        unique case (1'b1)
            (last_q == C_STRIP):
                ack_next_d = (num_vox_q != '0) ? S_VOX_FETCH : after_vox_d;
            (last_q == C_VOX):
                ack_next_d = (vox_inc_d < num_vox_q) ? S_VOX_FETCH : after_vox_d;
            (last_q == C_PAL):
                ack_next_d = (pal_inc_d < num_pal_q) ? S_PAL_FETCH : S_PIX_WR;
            (last_q == C_PIX):
                if (strip_end_d)
                    ack_next_d = (sp_next_d < PW'(TOTAL)) ? S_STRIP_WR : S_DONE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            last_q          <= C_STRIP;
            num_vox_q       <= '0;
            vox_idx_q       <= '0;
            num_pal_q       <= '0;
            pal_idx_q       <= '0;
            cam_q           <= '0;
            cam_idx_q       <= '0;
            start_pixel_q   <= '0;
            pix_q           <= '0;
            pix_cnt_q       <= '0;
            col_q           <= '0;
            row_q           <= '0;
            timer_q         <= '0;
            gpu_address_q   <= '0;
            gpu_read_q      <= 1'b0;
            gpu_write_q     <= 1'b0;
            gpu_writedata_q <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            error_code_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: if (start) begin
                    num_vox_q       <= num_voxels;
                    num_pal_q       <= num_palette;
                    cam_q           <= cam_words[479:32];
                    cam_idx_q       <= '0;
                    error_q         <= 1'b0;
                    error_code_q    <= '0;
                    start_pixel_q   <= '0;
                    pix_q           <= '0;
                    col_q           <= '0;
                    row_q           <= '0;
                    busy_q          <= 1'b1;
                    gpu_write_q     <= 1'b1;
                    gpu_address_q   <= 8'h10;
                    gpu_writedata_q <= cam_words[31:0];
                    state_q         <= S_CAM_WR;
                end
                S_CAM_WR: if (!gpu_waitrequest) begin
                    if (cam_idx_q == 4'd14) begin
                        gpu_address_q   <= 8'h03;
                        gpu_writedata_q <= 32'(start_pixel_q);
                        pix_cnt_q       <= '0;
                        state_q         <= S_STRIP_WR;
                    end else begin
                        cam_idx_q       <= cam_idx_q + 4'd1;
                        gpu_address_q   <= gpu_address_q + 8'd1;
                        gpu_writedata_q <= cam_q[31:0];
                        cam_q           <= cam_q >> 32;
                    end
                end
                S_STRIP_WR, S_PIX_WR: if (!gpu_waitrequest) begin
                    gpu_write_q <= 1'b0;
                    timer_q     <= '0;
                    state_q     <= S_WAIT_IRQ;
                    last_q      <= (state_q == S_PIX_WR) ? C_PIX : C_STRIP;
                    if (state_q == S_PIX_WR) begin
                        pix_q     <= pix_q + PW'(1);
                        pix_cnt_q <= pix_cnt_q + SW'(1);
                        if (col_q == COL_BITS'(H_RESOLUTION - 1)) begin
                            col_q <= '0;
                            row_q <= row_q + ROW_BITS'(1);
                        end else begin
                            col_q <= col_q + COL_BITS'(1);
                        end
                    end
                end
                S_VOX_FETCH: state_q <= S_VOX_WR;
                S_PAL_FETCH: state_q <= S_PAL_WR;
                // First WR cycle latches the RAM word, then the transfer runs.
                S_VOX_WR, S_PAL_WR: if (!gpu_write_q) begin
                    gpu_write_q     <= 1'b1;
                    gpu_address_q   <= (state_q == S_VOX_WR) ? 8'h00 : 8'h01;
                    gpu_writedata_q <= (state_q == S_VOX_WR) ? vox_rdata : pal_rdata;
                end else if (!gpu_waitrequest) begin
                    gpu_write_q <= 1'b0;
                    timer_q     <= '0;
                    state_q     <= S_WAIT_IRQ;
                    last_q      <= (state_q == S_VOX_WR) ? C_VOX : C_PAL;
                end
                S_WAIT_IRQ: if (gpu_irq) begin
                    gpu_read_q    <= 1'b1;
                    gpu_address_q <= 8'h0F;
                    state_q       <= S_ACK_RD;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    error_code_q    <= 2'd2;
                    gpu_write_q     <= 1'b1;
                    gpu_address_q   <= 8'h0F;
                    gpu_writedata_q <= 32'd1;
                    state_q         <= S_RECOVER;
                end else begin
                    timer_q <= timer_q + TW'(1);
                end
                S_ACK_RD: if (!gpu_waitrequest) begin
                    gpu_read_q <= 1'b0;
                    if (gpu_readdata != '0) begin
                        error_code_q    <= 2'd1;
                        gpu_write_q     <= 1'b1;
                        gpu_address_q   <= 8'h0F;
                        gpu_writedata_q <= 32'd1;
                        state_q         <= S_RECOVER;
                    end else begin
                        state_q       <= ack_next_d;
                        done_q        <= (ack_next_d == S_DONE);
                        gpu_write_q   <= (ack_next_d == S_STRIP_WR) ||
                                         (ack_next_d == S_PIX_WR);
                        gpu_address_q <= (ack_next_d == S_STRIP_WR) ? 8'h03 : 8'h02;
                        gpu_writedata_q <= (ack_next_d == S_STRIP_WR) ?
                                           32'(sp_next_d) : pix_word_d;
                        unique case (last_q)
                            C_STRIP: begin
                                vox_idx_q <= '0;
                                pal_idx_q <= '0;
                            end
                            C_VOX: vox_idx_q <= vox_inc_d;
                            C_PAL: pal_idx_q <= pal_inc_d;
                            C_PIX: if (strip_end_d) begin
                                start_pixel_q <= sp_next_d;
                                pix_cnt_q     <= '0;
                            end
                        endcase
                    end
                end
                S_RECOVER: if (!gpu_waitrequest) begin
                    gpu_write_q <= 1'b0;
                    error_q     <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_frame_sequencer.sv
// Bench for gpu_frame_sequencer: GPU slave model with irq/waitrequest,
// transfer scoreboard and error/timeout/reset scenarios on a 4x2 frame.
module tb_gpu_frame_sequencer;

    localparam int H     = 4;
    localparam int V     = 2;
    localparam int NS    = 4;
    localparam int VB    = 4;
    localparam int PB    = 4;
    localparam int TO    = 16;
    localparam int TOTAL = H * V;
    localparam int CB    = $clog2(H);

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [VB:0]    num_voxels = '0;
    logic [PB:0]    num_palette = '0;
    logic [479:0]   cam_words = '0;
    logic [VB-1:0]  vox_addr;
    logic [31:0]    vox_rdata = '0;
    logic [PB-1:0]  pal_addr;
    logic [31:0]    pal_rdata = '0;
    logic [7:0]     gpu_address;
    logic           gpu_read, gpu_write;
    logic [31:0]    gpu_writedata;
    logic [31:0]    gpu_readdata = '0;
    logic           gpu_waitrequest = 1'b0;
    logic           gpu_irq = 1'b0;
    logic           busy, done, error;
    logic [1:0]     error_code;

    gpu_frame_sequencer #(
        .H_RESOLUTION(H), .V_RESOLUTION(V), .NUM_SHADERS(NS),
        .VOX_ADDR_BITS(VB), .PAL_ADDR_BITS(PB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .num_voxels(num_voxels), .num_palette(num_palette),
        .cam_words(cam_words),
        .vox_addr(vox_addr), .vox_rdata(vox_rdata),
        .pal_addr(pal_addr), .pal_rdata(pal_rdata),
        .gpu_address(gpu_address), .gpu_read(gpu_read),
        .gpu_write(gpu_write), .gpu_writedata(gpu_writedata),
        .gpu_readdata(gpu_readdata), .gpu_waitrequest(gpu_waitrequest),
        .gpu_irq(gpu_irq), .busy(busy), .done(done),
        .error(error), .error_code(error_code)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    logic [40:0] exp_q[$];
    logic [40:0] act_q[$];
    int act_t[$];
    int cyc = 0, done_cnt = 0, stab_err = 0, both_err = 0;
    int wait_n = 0, irq_delay = 3, bad_addr = -1;
    bit irq_never = 1'b0;
    int left = 0, irq_cnt = 0, last_cmd = -1;
    bit stall_prev = 1'b0;
    logic [41:0] prev_snap = '0;
    logic [31:0] vox_mem[16];
    logic [31:0] pal_mem[16];

    always @(posedge clock) begin
        vox_rdata <= vox_mem[vox_addr];
        pal_rdata <= pal_mem[pal_addr];
    end

    // GPU slave model: decides waitrequest/readdata for the coming edge and
    // logs every transfer that will complete on it.
    always @(negedge clock) begin
        cyc++;
        if (!reset_n) begin
            gpu_waitrequest = 1'b0;
            gpu_irq = 1'b0;
            irq_cnt = 0;
            left = 0;
            stall_prev = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (gpu_read && gpu_write) both_err++;
            if (stall_prev && {gpu_read, gpu_write, gpu_address, gpu_writedata} !== prev_snap)
                stab_err++;
            if (irq_cnt > 0) begin
                irq_cnt--;
                if (irq_cnt == 0) gpu_irq = 1'b1;
            end
            if (gpu_read || gpu_write) begin
                if (!stall_prev) left = gpu_write ? wait_n : 0;
                if (left > 0) begin
                    gpu_waitrequest = 1'b1;
                    left--;
                end else begin
                    gpu_waitrequest = 1'b0;
                end
            end else begin
                gpu_waitrequest = 1'b0;
            end
            gpu_readdata = '0;
            if ((gpu_read || gpu_write) && !gpu_waitrequest) begin
                act_q.push_back({gpu_write, gpu_address, gpu_write ? gpu_writedata : 32'h0});
                act_t.push_back(cyc);
                if (gpu_write && gpu_address <= 8'd3) begin
                    last_cmd = int'(gpu_address);
                    if (!irq_never) irq_cnt = irq_delay;
                end
                if (gpu_read) begin
                    gpu_irq = 1'b0;
                    if (gpu_address == 8'h0F && last_cmd == bad_addr) gpu_readdata = 32'd2;
                end
            end
            stall_prev = (gpu_read || gpu_write) && gpu_waitrequest;
            prev_snap = {gpu_read, gpu_write, gpu_address, gpu_writedata};
        end
    end

    function automatic logic [31:0] pix_word(int p);
        return 32'(((p / H) << (CB + 1)) | ((p % H) << 1));
    endfunction

    task automatic push_w(int a, logic [31:0] d);
        exp_q.push_back({1'b1, 8'(a), d});
    endtask

    task automatic push_r();
        exp_q.push_back({1'b0, 8'h0F, 32'h0});
    endtask

    task automatic push_cam();
        for (int k = 0; k < 15; k++) push_w(16 + k, cam_words[32*k +: 32]);
    endtask

    task automatic push_frame(int nv, int np);
        push_cam();
        for (int sp = 0; sp < TOTAL; sp += NS) begin
            push_w(3, 32'(sp));
            push_r();
            for (int v = 0; v < nv; v++) begin
                push_w(0, vox_mem[v]);
                push_r();
            end
            for (int q = 0; q < np; q++) begin
                push_w(1, pal_mem[q]);
                push_r();
            end
            for (int p = sp; p < sp + NS && p < TOTAL; p++) begin
                push_w(2, pix_word(p));
                push_r();
            end
        end
    endtask

    task automatic kick(int nv, int np);
        @(negedge clock);
        num_voxels  = (VB + 1)'(nv);
        num_palette = (PB + 1)'(np);
        for (int k = 0; k < 15; k++) cam_words[32*k +: 32] = $urandom;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic next_xfer(output logic [40:0] x, output int t, output bit ok);
        int n = 0;
        while (act_q.size() == 0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        ok = (act_q.size() > 0);
        x = 'x;
        t = 0;
        if (ok) begin
            x = act_q.pop_front();
            t = act_t.pop_front();
        end
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clock);
            n++;
        end
        ok = !busy;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        vectors++;
        if ({vox_addr, pal_addr, gpu_address, gpu_read, gpu_write, gpu_writedata,
             busy, done, error, error_code} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got busy=%b wr=%b rd=%b adr=%h", busy, gpu_write, gpu_read, gpu_address);
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        vectors++;
        if ({gpu_read, gpu_write, busy, done, error} !== 5'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset got rd=%b wr=%b busy=%b", gpu_read, gpu_write, busy);
        end
    endtask

    task automatic test_frame(string tag);
        logic [40:0] e, a;
        int t, d0;
        bit ok;
        d0 = done_cnt;
        kick(1, 1);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_rise got %b want 1", tag, busy);
        end
        push_frame(1, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_xfer(a, t, ok);
            vectors++;
            if (!ok || a !== e) begin
                miscompares++;
                $display("FAIL %s xfer got %h want %h", tag, a, e);
                if (!ok) exp_q.delete();
            end
        end
        wait_idle(ok);
        repeat (3) @(negedge clock);
        vectors++;
        if (!ok || act_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s extra_xfers got %0d want 0 (idle=%b)", tag, act_q.size(), ok);
        end
        vectors++;
        if (done_cnt - d0 != 1 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_count got %0d want 1 error=%b", tag, done_cnt - d0, error);
        end
    endtask

    task automatic test_waitrequest();
        wait_n = 5;
        stab_err = 0;
        test_frame("waitreq");
        wait_n = 0;
        vectors++;
        if (stab_err != 0) begin
            miscompares++;
            $display("FAIL waitreq_stable got %0d changes want 0", stab_err);
        end
    endtask

    task automatic test_status_err();
        logic [40:0] e, a;
        int t, d0;
        bit ok;
        bad_addr = 0;
        d0 = done_cnt;
        kick(1, 1);
        push_cam();
        push_w(3, 32'd0);
        push_r();
        push_w(0, vox_mem[0]);
        push_r();
        push_w(15, 32'd1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_xfer(a, t, ok);
            vectors++;
            if (!ok || a !== e) begin
                miscompares++;
                $display("FAIL status_err xfer got %h want %h", a, e);
                if (!ok) exp_q.delete();
            end
        end
        wait_idle(ok);
        repeat (3) @(negedge clock);
        bad_addr = -1;
        vectors++;
        if (!ok || error !== 1'b1 || error_code !== 2'd1) begin
            miscompares++;
            $display("FAIL status_err_flags got err=%b code=%0d want 1/1", error, error_code);
        end
        vectors++;
        if (done_cnt != d0 || act_q.size() != 0) begin
            miscompares++;
            $display("FAIL status_err_nodone got done=%0d extra=%0d want 0/0", done_cnt - d0, act_q.size());
        end
    endtask

    task automatic test_timeout();
        logic [40:0] e, a;
        int t, t_strip, t_rec;
        bit ok;
        irq_never = 1'b1;
        t_strip = 0;
        t_rec = 0;
        kick(1, 1);
        push_cam();
        push_w(3, 32'd0);
        push_w(15, 32'd1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_xfer(a, t, ok);
            if (e[39:32] == 8'h03) t_strip = t;
            if (e[39:32] == 8'h0F) t_rec = t;
            vectors++;
            if (!ok || a !== e) begin
                miscompares++;
                $display("FAIL timeout xfer got %h want %h", a, e);
                if (!ok) exp_q.delete();
            end
        end
        wait_idle(ok);
        irq_never = 1'b0;
        vectors++;
        if (t_rec - t_strip - 1 != TO) begin
            miscompares++;
            $display("FAIL timeout_gap got %0d want %0d", t_rec - t_strip - 1, TO);
        end
        vectors++;
        if (!ok || error !== 1'b1 || error_code !== 2'd2) begin
            miscompares++;
            $display("FAIL timeout_flags got err=%b code=%0d want 1/2", error, error_code);
        end
    endtask

    task automatic test_empty_tables();
        logic [40:0] e, a;
        int t, d0;
        bit ok;
        d0 = done_cnt;
        kick(0, 0);
        push_frame(0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_xfer(a, t, ok);
            vectors++;
            if (!ok || a !== e) begin
                miscompares++;
                $display("FAIL empty xfer got %h want %h", a, e);
                if (!ok) exp_q.delete();
            end
        end
        wait_idle(ok);
        repeat (3) @(negedge clock);
        vectors++;
        if (!ok || done_cnt - d0 != 1 || act_q.size() != 0 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_end got done=%0d extra=%0d err=%b want 1/0/0", done_cnt - d0, act_q.size(), error);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        kick(1, 1);
        while (!(gpu_write && gpu_address == 8'h02) && n < 5000) begin
            @(negedge clock);
            n++;
        end
        vectors++;
        if (!(gpu_write && gpu_address == 8'h02)) begin
            miscompares++;
            $display("FAIL reset_mid_reach got adr=%h wr=%b want pixel write", gpu_address, gpu_write);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({vox_addr, pal_addr, gpu_address, gpu_read, gpu_write, gpu_writedata,
             busy, done, error, error_code} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs got busy=%b wr=%b adr=%h data=%h", busy, gpu_write, gpu_address, gpu_writedata);
        end
        @(negedge clock);
        reset_n = 1'b1;
        exp_q.delete();
        act_q.delete();
        act_t.delete();
        test_frame("post_reset");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            vox_mem[i] = $urandom;
            pal_mem[i] = $urandom;
        end
        test_reset();
        test_frame("frame");
        test_waitrequest();
        test_status_err();
        test_timeout();
        test_empty_tables();
        test_reset_mid();
        vectors++;
        if (both_err != 0) begin
            miscompares++;
            $display("FAIL rd_wr_overlap got %0d want 0", both_err);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
